// File: rtl/host_frame_receiver_if.sv
// Frame-memory write port and buffer-swap handshake between the host frame
// receiver (master) and the LED-driver controller / frame memory (slave).
interface host_frame_receiver_if #(
    parameter int ADDR_W = 12
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              buf_sel;
    logic              swap_req;
    logic              swap_ack;

    modport master (
        output wr_en, wr_addr, wr_data, buf_sel, swap_req,
        input  swap_ack
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, buf_sel, swap_req,
        output swap_ack
    );
endinterface

// File: rtl/host_frame_receiver.sv
// SPI (mode 0) slave that writes CMD_FRAME-prefixed RGB frames into the back buffer and
// requests a buffer swap. Define HOST_FRAME_CHECKSUM_EN to require a trailing XOR byte.
module host_frame_receiver #(
    parameter int         NUM_PIXELS = 4096,
    parameter int         ADDR_W     = 12,
    parameter logic [7:0] CMD_FRAME  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spi_sclk,
    input  logic                  spi_mosi,
    input  logic                  spi_cs_n,
    host_frame_receiver_if.master fb,
    output logic                  frame_error,
    output logic                  busy
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE, CMD, PIXEL, CKSUM, FULL, DRAIN, WAIT_SWAP
    } state_t;

`ifdef HOST_FRAME_CHECKSUM_EN
    localparam state_t AFTER_PIX = CKSUM;
`else
    localparam state_t AFTER_PIX = FULL;
`endif

    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_p0, cs_p1, cs_p2;
    logic mosi_p0, mosi_p1;
    logic sclk_rise, cs_fall, cs_rise, bit_take;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       byte_vld_p;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  pix_cnt, pix_cnt_nx;
    logic [1:0]        rgb_idx, rgb_idx_nx;
    logic [7:0]        r_byte, r_nx, g_byte, g_nx;
    logic              wr_en, wr_en_nx;
    logic [ADDR_W-1:0] wr_addr, wr_addr_nx;
    logic [23:0]       wr_data, wr_data_nx;
    logic              err_nx;
    logic              swap_req, swap_req_nx;
    logic              buf_sel, buf_sel_nx;
    logic              pend_drain, pend_nx;
`ifdef HOST_FRAME_CHECKSUM_EN
    logic [7:0]        ck_xor, ck_nx;
`endif

    // Stage p0/p1: two-flop synchronisers; p2 holds the previous value for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_p0    <= 1'b0;
            sclk_p1    <= 1'b0;
            sclk_p2    <= 1'b0;
            cs_p0      <= 1'b1;
            cs_p1      <= 1'b1;
            cs_p2      <= 1'b1;
            mosi_p0    <= 1'b0;
            mosi_p1    <= 1'b0;
            bit_cnt    <= 3'd0;
            byte_vld_p <= 1'b0;
        end else begin
            sclk_p0 <= spi_sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= spi_cs_n;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
            mosi_p0 <= spi_mosi;
            mosi_p1 <= mosi_p0;
            if (cs_fall) begin
                bit_cnt    <= 3'd0;
                byte_vld_p <= 1'b0;
            end else begin
                byte_vld_p <= bit_take && (bit_cnt == 3'd7);
                if (bit_take)
                    bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign cs_fall   = cs_p2 & ~cs_p1;
    assign cs_rise   = ~cs_p2 & cs_p1;
    assign bit_take  = sclk_rise & ~cs_p1;

    always_ff @(posedge clk) begin
        if (cs_fall)
            shift <= 8'd0;
        else if (bit_take)
            shift <= {shift[6:0], mosi_p1};
        r_byte <= r_nx;
        g_byte <= g_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pix_cnt     <= '0;
            rgb_idx     <= 2'd0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 24'd0;
            frame_error <= 1'b0;
            swap_req    <= 1'b0;
            buf_sel     <= 1'b0;
            pend_drain  <= 1'b0;
`ifdef HOST_FRAME_CHECKSUM_EN
            ck_xor      <= 8'd0;
`endif
        end else begin
            state       <= state_nx;
            pix_cnt     <= pix_cnt_nx;
            rgb_idx     <= rgb_idx_nx;
            wr_en       <= wr_en_nx;
            wr_addr     <= wr_addr_nx;
            wr_data     <= wr_data_nx;
            frame_error <= err_nx;
            swap_req    <= swap_req_nx;
            buf_sel     <= buf_sel_nx;
            pend_drain  <= pend_nx;
`ifdef HOST_FRAME_CHECKSUM_EN
            ck_xor      <= ck_nx;
`endif
        end
    end

    always_comb begin
        state_nx    = state;
        pix_cnt_nx  = pix_cnt;
        rgb_idx_nx  = rgb_idx;
        r_nx        = r_byte;
        g_nx        = g_byte;
        wr_en_nx    = 1'b0;
        wr_addr_nx  = wr_addr;
        wr_data_nx  = wr_data;
        err_nx      = frame_error;
        swap_req_nx = swap_req;
        buf_sel_nx  = buf_sel;
        pend_nx     = pend_drain;
`ifdef HOST_FRAME_CHECKSUM_EN
        ck_nx       = ck_xor;
`endif

        // Address saturates at the top instead of wrapping back onto pixel 0
        if (wr_en && (wr_addr != {ADDR_W{1'b1}}))
            wr_addr_nx = wr_addr + 1'b1;

        if (byte_vld_p) begin
            case (state)
                CMD: begin
                    if (shift == CMD_FRAME) begin
                        state_nx = PIXEL;
                    end else begin
                        state_nx = DRAIN;
                        err_nx   = 1'b1;
                    end
                end
                PIXEL: begin
`ifdef HOST_FRAME_CHECKSUM_EN
                    ck_nx = ck_xor ^ shift;
`endif
                    case (rgb_idx)
                        2'd0: begin
                            r_nx       = shift;
                            rgb_idx_nx = 2'd1;
                        end
                        2'd1: begin
                            g_nx       = shift;
                            rgb_idx_nx = 2'd2;
                        end
                        default: begin
                            wr_en_nx   = 1'b1;
                            wr_data_nx = {r_byte, g_byte, shift};
                            rgb_idx_nx = 2'd0;
                            pix_cnt_nx = pix_cnt + 1'b1;
                            if (pix_cnt == LAST_PIX)
                                state_nx = AFTER_PIX;
                        end
                    endcase
                end
`ifdef HOST_FRAME_CHECKSUM_EN
                CKSUM: begin
                    if (shift == ck_xor) begin
                        state_nx = FULL;
                    end else begin
                        state_nx = DRAIN;
                        err_nx   = 1'b1;
                    end
                end
`endif
                FULL: begin
                    state_nx = DRAIN;
                    err_nx   = 1'b1;
                end
                default: ;
            endcase
        end

        // A byte landing with cs_n rise is already folded into state_nx above
        if (cs_rise) begin
            case (state_nx)
                CMD, PIXEL, CKSUM: begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end
                FULL: begin
                    state_nx    = WAIT_SWAP;
                    swap_req_nx = 1'b1;
                end
                DRAIN:     state_nx = IDLE;
                WAIT_SWAP: pend_nx  = 1'b0;
                default: ;
            endcase
        end

        if (cs_fall) begin
            if (state == IDLE) begin
                state_nx   = CMD;
                pix_cnt_nx = '0;
                rgb_idx_nx = 2'd0;
                wr_addr_nx = '0;
`ifdef HOST_FRAME_CHECKSUM_EN
                ck_nx      = 8'd0;
`endif
            end else if (state == WAIT_SWAP) begin
                err_nx  = 1'b1;
                pend_nx = 1'b1;
            end
        end

        // A transaction opened while waiting is still in flight after the ack: drain it
        if ((state == WAIT_SWAP) && fb.swap_ack) begin
            swap_req_nx = 1'b0;
            buf_sel_nx  = ~buf_sel;
            state_nx    = pend_nx ? DRAIN : IDLE;
            pend_nx     = 1'b0;
        end
    end

    assign fb.wr_en    = wr_en;
    assign fb.wr_addr  = wr_addr;
    assign fb.wr_data  = wr_data;
    assign fb.buf_sel  = buf_sel;
    assign fb.swap_req = swap_req;
    assign busy        = (state != IDLE) || swap_req;

endmodule

// File: tb/tb_host_frame_receiver.sv
// Directed bench for host_frame_receiver with a 4-pixel frame: full, bad-command, short,
// long, withheld-ack, mid-frame reset and back-to-back frames.
module tb_host_frame_receiver;
    logic clk = 1'b0;
    logic reset_n;
    logic spi_sclk, spi_mosi, spi_cs_n;
    logic frame_error, busy;

    int errors = 0;
    int checks = 0;

    host_frame_receiver_if #(.ADDR_W(12)) fb ();

    host_frame_receiver #(
        .NUM_PIXELS(4),
        .ADDR_W    (12),
        .CMD_FRAME (8'hA5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n),
        .fb         (fb),
        .frame_error(frame_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Write log and buf_sel toggle count, sampled on the falling edge
    int          wr_total = 0;
    int          toggles  = 0;
    logic        buf_sel_prev = 1'b0;
    logic [11:0] log_addr [0:63];
    logic [23:0] log_data [0:63];

    always @(negedge clk) begin
        if (fb.wr_en === 1'b1) begin
            if (wr_total < 64) begin
                log_addr[wr_total] = fb.wr_addr;
                log_data[wr_total] = fb.wr_data;
            end
            wr_total = wr_total + 1;
        end
        if (fb.buf_sel !== buf_sel_prev)
            toggles = toggles + 1;
        buf_sel_prev = fb.buf_sel;
    end

    task automatic do_reset();
        reset_n     = 1'b0;
        spi_cs_n    = 1'b1;
        spi_sclk    = 1'b0;
        spi_mosi    = 1'b0;
        fb.swap_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = b[i];
            #50 spi_sclk = 1'b1;
            #50 spi_sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] first, input int n);
        logic [7:0] b;
        spi_cs_n = 1'b0;
        #100;
        spi_byte(cmd);
        for (int i = 0; i < n; i++) begin
            b = first + 8'(i);
            spi_byte(b);
        end
        #100 spi_cs_n = 1'b1;
        #200;
    endtask

    task automatic pulse_ack();
        @(posedge clk);
        #1 fb.swap_ack = 1'b1;
        @(posedge clk);
        #1 fb.swap_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (fb.wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b expected 0", fb.wr_en); end
        checks++; if (fb.wr_addr !== 12'h000) begin errors++; $display("FAIL rst_wr_addr: got %h expected 000", fb.wr_addr); end
        checks++; if (fb.wr_data !== 24'h000000) begin errors++; $display("FAIL rst_wr_data: got %h expected 000000", fb.wr_data); end
        checks++; if (fb.buf_sel !== 1'b0) begin errors++; $display("FAIL rst_buf_sel: got %b expected 0", fb.buf_sel); end
        checks++; if (fb.swap_req !== 1'b0) begin errors++; $display("FAIL rst_swap_req: got %b expected 0", fb.swap_req); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL rst_frame_error: got %b expected 0", frame_error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    endtask

    task automatic test_full_frame();
        logic [23:0] exp_d [4] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
        int base;
        do_reset();
        base = wr_total;
        send_frame(8'hA5, 8'h01, 12);
        checks++; if (wr_total - base !== 4) begin errors++; $display("FAIL full_wr_count: got %0d expected 4", wr_total - base); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (log_addr[base+k] !== 12'(k)) begin errors++; $display("FAIL full_addr%0d: got %h expected %h", k, log_addr[base+k], 12'(k)); end
            checks++; if (log_data[base+k] !== exp_d[k]) begin errors++; $display("FAIL full_data%0d: got %h expected %h", k, log_data[base+k], exp_d[k]); end
        end
        checks++; if (fb.wr_addr !== 12'h004) begin errors++; $display("FAIL full_addr_end: got %h expected 004", fb.wr_addr); end
        checks++; if (fb.swap_req !== 1'b1) begin errors++; $display("FAIL full_swap_req: got %b expected 1", fb.swap_req); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_wait: got %b expected 1", busy); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL full_frame_error: got %b expected 0", frame_error); end
        checks++; if (fb.buf_sel !== 1'b0) begin errors++; $display("FAIL full_buf_sel_pre: got %b expected 0", fb.buf_sel); end
        pulse_ack();
        checks++; if (fb.buf_sel !== 1'b1) begin errors++; $display("FAIL full_buf_sel: got %b expected 1", fb.buf_sel); end
        checks++; if (fb.swap_req !== 1'b0) begin errors++; $display("FAIL full_swap_drop: got %b expected 0", fb.swap_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_idle: got %b expected 0", busy); end
    endtask

    task automatic test_bad_cmd();
        int base;
        do_reset();
        base = wr_total;
        send_frame(8'h5A, 8'h01, 12);
        checks++; if (wr_total - base !== 0) begin errors++; $display("FAIL badcmd_wr_count: got %0d expected 0", wr_total - base); end
        checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL badcmd_frame_error: got %b expected 1", frame_error); end
        checks++; if (fb.swap_req !== 1'b0) begin errors++; $display("FAIL badcmd_swap_req: got %b expected 0", fb.swap_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badcmd_busy: got %b expected 0", busy); end
    endtask

    task automatic test_short_frame();
        int base;
        do_reset();
        base = wr_total;
        send_frame(8'hA5, 8'h01, 6);
        checks++; if (wr_total - base !== 2) begin errors++; $display("FAIL short_wr_count: got %0d expected 2", wr_total - base); end
        checks++; if (log_data[base] !== 24'h010203) begin errors++; $display("FAIL short_data0: got %h expected 010203", log_data[base]); end
        checks++; if (log_data[base+1] !== 24'h040506) begin errors++; $display("FAIL short_data1: got %h expected 040506", log_data[base+1]); end
        checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL short_frame_error: got %b expected 1", frame_error); end
        checks++; if (fb.swap_req !== 1'b0) begin errors++; $display("FAIL short_swap_req: got %b expected 0", fb.swap_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_busy: got %b expected 0", busy); end
    endtask

    task automatic test_long_frame();
        int base;
        do_reset();
        base = wr_total;
        send_frame(8'hA5, 8'h01, 13);
        checks++; if (wr_total - base !== 4) begin errors++; $display("FAIL long_wr_count: got %0d expected 4", wr_total - base); end
        checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL long_frame_error: got %b expected 1", frame_error); end
        checks++; if (fb.swap_req !== 1'b0) begin errors++; $display("FAIL long_swap_req: got %b expected 0", fb.swap_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL long_busy: got %b expected 0", busy); end
    endtask

    task automatic test_withheld_ack();
        int base;
        int tog_base;
        do_reset();
        tog_base = toggles;
        send_frame(8'hA5, 8'h01, 12);
        checks++; if (fb.swap_req !== 1'b1) begin errors++; $display("FAIL hold_swap_req: got %b expected 1", fb.swap_req); end
        base = wr_total;
        spi_cs_n = 1'b0;
        #100;
        spi_byte(8'hA5);
        spi_byte(8'h01);
        spi_byte(8'h02);
        #200;
        checks++; if (wr_total - base !== 0) begin errors++; $display("FAIL hold_wr_count_pre: got %0d expected 0", wr_total - base); end
        checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL hold_frame_error: got %b expected 1", frame_error); end
        checks++; if (fb.swap_req !== 1'b1) begin errors++; $display("FAIL hold_swap_kept: got %b expected 1", fb.swap_req); end
        pulse_ack();
        checks++; if (fb.buf_sel !== 1'b1) begin errors++; $display("FAIL hold_buf_sel: got %b expected 1", fb.buf_sel); end
        checks++; if (fb.swap_req !== 1'b0) begin errors++; $display("FAIL hold_swap_drop: got %b expected 0", fb.swap_req); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy_drain: got %b expected 1", busy); end
        spi_byte(8'h03);
        spi_byte(8'h04);
        spi_byte(8'h05);
        #100 spi_cs_n = 1'b1;
        #200;
        checks++; if (wr_total - base !== 0) begin errors++; $display("FAIL hold_wr_count_post: got %0d expected 0", wr_total - base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy_idle: got %b expected 0", busy); end
        checks++; if (toggles - tog_base !== 1) begin errors++; $display("FAIL hold_toggles: got %0d expected 1", toggles - tog_base); end
    endtask

    task automatic test_reset_mid();
        logic [23:0] exp_d [4] = '{24'h101112, 24'h131415, 24'h161718, 24'h191A1B};
        int base;
        spi_cs_n = 1'b0;
        #100;
        spi_byte(8'hA5);
        spi_byte(8'h01);
        spi_byte(8'h02);
        spi_byte(8'h03);
        spi_byte(8'h04);
        #100;
        reset_n  = 1'b0;
        spi_cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (fb.wr_addr !== 12'h000) begin errors++; $display("FAIL mid_wr_addr: got %h expected 000", fb.wr_addr); end
        checks++; if (fb.wr_data !== 24'h000000) begin errors++; $display("FAIL mid_wr_data: got %h expected 000000", fb.wr_data); end
        checks++; if (fb.buf_sel !== 1'b0) begin errors++; $display("FAIL mid_buf_sel: got %b expected 0", fb.buf_sel); end
        checks++; if (fb.swap_req !== 1'b0) begin errors++; $display("FAIL mid_swap_req: got %b expected 0", fb.swap_req); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL mid_frame_error: got %b expected 0", frame_error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        base = wr_total;
        send_frame(8'hA5, 8'h10, 12);
        checks++; if (wr_total - base !== 4) begin errors++; $display("FAIL mid_wr_count: got %0d expected 4", wr_total - base); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (log_addr[base+k] !== 12'(k)) begin errors++; $display("FAIL mid_addr%0d: got %h expected %h", k, log_addr[base+k], 12'(k)); end
            checks++; if (log_data[base+k] !== exp_d[k]) begin errors++; $display("FAIL mid_data%0d: got %h expected %h", k, log_data[base+k], exp_d[k]); end
        end
        checks++; if (fb.swap_req !== 1'b1) begin errors++; $display("FAIL mid_swap_req_set: got %b expected 1", fb.swap_req); end
        pulse_ack();
        checks++; if (fb.buf_sel !== 1'b1) begin errors++; $display("FAIL mid_buf_sel_swap: got %b expected 1", fb.buf_sel); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL mid_frame_error_end: got %b expected 0", frame_error); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_d [4] = '{24'h202122, 24'h232425, 24'h262728, 24'h292A2B};
        int base;
        base = wr_total;
        send_frame(8'hA5, 8'h20, 12);
        checks++; if (wr_total - base !== 4) begin errors++; $display("FAIL b2b_wr_count: got %0d expected 4", wr_total - base); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (log_addr[base+k] !== 12'(k)) begin errors++; $display("FAIL b2b_addr%0d: got %h expected %h", k, log_addr[base+k], 12'(k)); end
            checks++; if (log_data[base+k] !== exp_d[k]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", k, log_data[base+k], exp_d[k]); end
        end
        checks++; if (fb.swap_req !== 1'b1) begin errors++; $display("FAIL b2b_swap_req: got %b expected 1", fb.swap_req); end
        pulse_ack();
        checks++; if (fb.buf_sel !== 1'b0) begin errors++; $display("FAIL b2b_buf_sel: got %b expected 0", fb.buf_sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_bad_cmd();
        test_short_frame();
        test_long_frame();
        test_withheld_ack();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/host_frame_receiver.md
Name: host_frame_receiver

Overview:
- SPI slave that receives full-cube colour frames from the host link and writes them as 24-bit RGB pixels into the back half of the double-buffered frame memory.
- Sits directly upstream of the LED-driver controller, which reads the front buffer.
- On a complete, valid frame it requests a buffer swap; the controller acknowledges the swap at its next frame boundary.

Parameters:
- NUM_PIXELS, 4096, number of RGB pixels per frame (16x16x16 cube).
- ADDR_W, 12, width of the pixel write address; must satisfy 2**ADDR_W >= NUM_PIXELS.
- CMD_FRAME, 8'hA5, command byte that opens a frame write.

Ports:
- clk  input  1  system clock (50 MHz).
- reset_n  input  1  asynchronous active-low reset.
- spi_sclk  input  1  host SPI clock, asynchronous; mode 0, max clk/8.
- spi_mosi  input  1  host SPI data, MSB first, asynchronous.
- spi_cs_n  input  1  host chip select, active low, asynchronous.
- wr_en  output  1  one-cycle pixel write strobe to frame memory.
- wr_addr  output  ADDR_W  pixel index within the back buffer.
- wr_data  output  24  pixel {R,G,B}, R in bits 23:16.
- buf_sel  output  1  back-buffer select; the controller displays ~buf_sel.
- swap_req  output  1  level; requests the controller to swap buffers.
- swap_ack  input  1  one-cycle pulse from the controller; swap done.
- frame_error  output  1  sticky; bad command, short, long or dropped frame.
- busy  output  1  high while a transaction is open or a swap is pending.

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0. Reset mid-transaction discards the partial frame; no swap_req follows.
- Input sync: spi_sclk, spi_mosi and spi_cs_n each pass through a 2-flop synchroniser.
  - sclk rise is detected on the synchronised signal.
  - mosi is sampled on the detected rise.
  - cs_n fall and rise are edge-detected after sync.
- Bit/byte assembly: 3-bit bit counter and 8-bit shift register.
  - Both clear on every cs_n fall.
  - A byte completes on the 8th sampled bit.
- States:
  - IDLE: on cs_n fall -> CMD. wr_addr is cleared to 0 and the pixel counter is cleared.
  - CMD: first byte equal to CMD_FRAME -> PIXEL. Any other value -> DRAIN and set frame_error.
  - PIXEL: bytes rotate through R, G, B.
    - When the B byte completes, assert wr_en with wr_data={R,G,B} in the cycle after completion, for exactly 1 cycle.
    - wr_addr increments the cycle after wr_en; no wrap.
    - After NUM_PIXELS writes -> FULL.
  - FULL: any further complete byte sets frame_error and moves to DRAIN.
  - DRAIN: ignore bytes until cs_n rise -> IDLE; no swap.
  - cs_n rise in FULL with pixel count == NUM_PIXELS -> WAIT_SWAP, and swap_req rises the next cycle.
  - cs_n rise in PIXEL or CMD (short frame) -> set frame_error, go to IDLE, no swap. Partial writes remain in the back buffer.
  - WAIT_SWAP: swap_req held high until swap_ack.
    - On swap_ack: swap_req drops the next cycle, buf_sel toggles in the same edge, state -> IDLE.
    - A cs_n fall while in WAIT_SWAP sets frame_error; that transaction goes to DRAIN after the ack.
    - Bytes from that transaction are never written.
- swap_ack outside WAIT_SWAP is ignored.
- A cs_n rise and a byte completion in the same cycle: the byte is processed first, then the cs_n rise.
- busy = (state != IDLE) || swap_req.
- frame_error clears only on reset.

Optional Feature:
- Macro HOST_FRAME_CHECKSUM_EN.
- Defined:
  - After the last pixel, one extra byte is required, equal to the XOR of all pixel bytes.
  - cs_n rise with a matching checksum -> WAIT_SWAP.
  - Checksum mismatch, or a missing checksum byte -> frame_error set, no swap.
  - Bytes after the checksum byte -> frame_error set, DRAIN.
- Undefined: no checksum byte and no XOR logic; the behaviour above applies unchanged.

Test Plan:
- NUM_PIXELS=4. Send A5 then 12 bytes 01..0C, raise cs_n -> wr_en pulses at addr 0..3 with data 010203, 040506, 0708090A... i.e. 010203/040506/070809/0A0B0C; swap_req=1. Pulse swap_ack -> buf_sel=1, swap_req=0, busy=0.
- Send command 5A plus 12 bytes -> no wr_en, frame_error=1, swap_req stays 0.
- Send A5 plus 6 bytes (short frame), raise cs_n -> 2 writes, frame_error=1, no swap_req.
- Full frame plus 1 extra byte -> 4 writes, frame_error=1, no swap_req.
- Full frame with swap_ack withheld, then a second cs_n fall plus bytes -> no wr_en and frame_error=1. After swap_ack, buf_sel toggles exactly once.
- Assert reset_n low mid-pixel, then release -> all outputs 0; a fresh full frame writes from addr 0 and swaps normally.
